acp_xfer_splitter: RTL and testbench
====================================

// Module: acp_xfer_splitter
// PURPOSE
// Upstream command generator for the ACP RAM-to-AXI mover. Takes one byte-granular transfer request
// (direction, AXI byte address, ACP RAM word address, byte count) and splits it into 1-beat (16 B)
// or 4-beat (64 B) mover commands. Per command it drives the remote write strobes and local ACP RAM
// write strobes, sequences the commands over the mover's busy/done handshake, and reports one
// completion with sticky error. No data shifting: AXI byte lane == ACP RAM byte lane (addr[3:0]).
// PARAMETERS
// AXI_ADDR_WIDTH     32  AXI byte address width
// ACPRAM_ADDR_WIDTH  10  ACP RAM word address width (1 word = 16 B)
// LEN_WIDTH          16  request byte count width
// PORTS
// clock                  in   1          clock
// resetn                 in   1          reset, synchronous, active-low
// req_valid              in   1          request valid
// req_ready              out  1          request accept (high only in IDLE)
// req_write              in   1          1 = ACP RAM -> AXI, 0 = AXI -> ACP RAM
// req_axi_addr           in   AXI_ADDR_WIDTH     start byte address
// req_acpram_addr        in   ACPRAM_ADDR_WIDTH  start ACP RAM word
// req_len                in   LEN_WIDTH  byte count, 0 allowed
// cmp_valid              out  1          1-cycle completion pulse
// cmp_error              out  1          sticky OR of mover errors, valid with cmp_valid
// cmd_write, cmd_read    out  1          1-cycle command pulses to mover
// cmd_axi_addr           out  AXI_ADDR_WIDTH     command AXI address (held until done)
// cmd_acpram_addr        out  ACPRAM_ADDR_WIDTH  command ACP RAM word (held)
// cmd_len                out  1          0 = 1 beat, 1 = 4 beats
// cmd_busy, cmd_done, cmd_error  in  1  mover status; done is a 1-cycle pulse
// acp_remote_wstrb_0     out  16         byte strobe for a 1-beat write
// acp_remote_wstrb_0123  out  4          per-beat strobe for a 4-beat write
// acp_local_wstrb[4]     out  16 each    ACP RAM byte enables per read beat
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1; all other outputs 0; accumulators cleared.
// - Reset mid-operation: abort to IDLE immediately. No cmp_valid is issued.
// - FSM states:
//   - IDLE: on req_valid&&req_ready, latch the request and clear err.
//     - len==0: go to FIN.
//     - else: go to ISSUE.
//   - ISSUE: wait for cmd_busy==0, then compute the chunk, drive cmd_* and the strobes, and pulse
//     cmd_write/cmd_read (per dir) exactly 1 cycle. Go to WAIT.
//   - WAIT: on cmd_done, set err|=cmd_error and advance:
//     - axi_addr += bytes; acpram_addr += 4 (burst) or 1 (single); rem -= bytes.
//     - rem==0: go to FIN; else go to ISSUE.
//   - FIN: cmp_valid=1 and cmp_error=err for 1 cycle, then go to IDLE.
// - Chunk rule, with off=axi_addr[3:0]:
//   - Burst if axi_addr[5:0]==0 && rem>=64: cmd_len=1, bytes=64; wstrb_0123=4'hF; all local=16'hFFFF.
//   - Else single: cmd_len=0, bytes=min(16-off, rem), mask=((1<<bytes)-1)<<off (17-bit arithmetic,
//     truncated to 16). wstrb_0=mask; local[0]=mask; local[1..3]=0; wstrb_0123=4'b0001.
// - Strobes and cmd_* stay stable from the pulse cycle until the cycle after cmd_done.
// - Latency: accept at cycle N gives the first cmd pulse at N+1 when the mover is idle. The final
//   cmd_done at cycle M gives cmp_valid at M+1. With len==0, cmp_valid is at N+1.
// - Addresses wrap modulo their width. rem never underflows (bytes<=rem by construction).
// - A cmd_done seen outside WAIT is ignored.
// TESTING
// - Write, axi 0x1000, acpram 0x000, len 128 -> 2 cmd_write pulses, cmd_len=1, acpram 0x000 then
//   0x004, axi 0x1000 then 0x1040, wstrb_0123=F; one cmp_valid, cmp_error=0.
// - Write, axi 0x1005, acpram 0x010, len 20 -> cmd 1: axi 0x1005, acpram 0x010, wstrb_0=0xFFE0;
//   cmd 2: axi 0x1010, acpram 0x011, wstrb_0=0x01FF.
// - Read, axi 0x1030, len 64 -> 4 single cmd_read pulses (0x1030, 0x1040, 0x1050, 0x1060), each
//   local[0]=0xFFFF, cmd_len=0.
// - len 0 -> no cmd pulse; cmp_valid exactly 1 cycle after accept; req_ready low for only 1 cycle.
// - cmd_error=1 on chunk 2 of 3 -> chunk 3 still issued; cmp_error=1 with cmp_valid.
// - resetn low during WAIT -> next cycle state IDLE, req_ready=1, cmd pulses 0, no cmp_valid.

Source files
------------

// File: rtl/acp_xfer_splitter.sv
// Splits one byte-granular ACP RAM <-> AXI transfer request into 16 B / 64 B mover commands
// and reports a single completion with sticky error.
module acp_xfer_splitter #(
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int ACPRAM_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [AXI_ADDR_WIDTH-1:0]    req_axi_addr,
    input  logic [ACPRAM_ADDR_WIDTH-1:0] req_acpram_addr,
    input  logic [LEN_WIDTH-1:0]         req_len,
    output logic                         cmp_valid,
    output logic                         cmp_error,
    output logic                         cmd_write,
    output logic                         cmd_read,
    output logic [AXI_ADDR_WIDTH-1:0]    cmd_axi_addr,
    output logic [ACPRAM_ADDR_WIDTH-1:0] cmd_acpram_addr,
    output logic                         cmd_len,
    input  logic                         cmd_busy,
    input  logic                         cmd_done,
    input  logic                         cmd_error,
    output logic [15:0]                  acp_remote_wstrb_0,
    output logic [3:0]                   acp_remote_wstrb_0123,
    output logic [15:0]                  acp_local_wstrb [4]
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t                         state, state_nx;
    logic                           dir_q;
    logic [AXI_ADDR_WIDTH-1:0]      axi_addr_q;
    logic [ACPRAM_ADDR_WIDTH-1:0]   acpram_addr_q;
    logic [LEN_WIDTH-1:0]           rem_q;
    logic                           err_q;

    logic [3:0]                     off;
    logic [4:0]                     room;
    logic [4:0]                     single_bytes;
    logic                           burst;
    logic [6:0]                     chunk_bytes;
    logic [15:0]                    single_mask;

    // Chunk is derived from the live cursor; the cursor only moves on cmd_done, which keeps
    // cmd_* and the strobes stable from the pulse through the done cycle.
    always_comb begin
        off          = axi_addr_q[3:0];
        room         = 5'd16 - {1'b0, off};
        burst        = (axi_addr_q[5:0] == 6'd0) && (rem_q >= LEN_WIDTH'(64));
        single_bytes = (rem_q < LEN_WIDTH'(room)) ? rem_q[4:0] : room;
        single_mask  = 16'((17'd1 << single_bytes) - 17'd1) << off;
        chunk_bytes  = burst ? 7'd64 : {2'b00, single_bytes};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx              = state;
        req_ready             = 1'b0;
        cmp_valid             = 1'b0;
        cmp_error             = 1'b0;
        cmd_write             = 1'b0;
        cmd_read              = 1'b0;
        cmd_axi_addr          = '0;
        cmd_acpram_addr       = '0;
        cmd_len               = 1'b0;
        acp_remote_wstrb_0    = '0;
        acp_remote_wstrb_0123 = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            acp_local_wstrb[k] = '0;
        end

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = (req_len == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                cmd_axi_addr    = axi_addr_q;
                cmd_acpram_addr = acpram_addr_q;
                cmd_len         = burst;
                if (burst) begin
                    acp_remote_wstrb_0    = '1;
                    acp_remote_wstrb_0123 = 4'hF;
                    for (int unsigned k = 0; k < 4; k++) begin
                        acp_local_wstrb[k] = '1;
                    end
                end else begin
                    acp_remote_wstrb_0    = single_mask;
                    acp_remote_wstrb_0123 = 4'b0001;
                    acp_local_wstrb[0]    = single_mask;
                end
                if (state == S_ISSUE && !cmd_busy) begin
                    cmd_write = dir_q;
                    cmd_read  = !dir_q;
                    state_nx  = S_WAIT;
                end
                if (state == S_WAIT && cmd_done) begin
                    state_nx = (rem_q == LEN_WIDTH'(chunk_bytes)) ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                cmp_valid = 1'b1;
                cmp_error = err_q;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dir_q         <= 1'b0;
            axi_addr_q    <= '0;
            acpram_addr_q <= '0;
            rem_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                dir_q         <= req_write;
                axi_addr_q    <= req_axi_addr;
                acpram_addr_q <= req_acpram_addr;
                rem_q         <= req_len;
                err_q         <= 1'b0;
            end
            if (state == S_WAIT && cmd_done) begin
                err_q         <= err_q | cmd_error;
                axi_addr_q    <= axi_addr_q + AXI_ADDR_WIDTH'(chunk_bytes);
                acpram_addr_q <= acpram_addr_q + (burst ? ACPRAM_ADDR_WIDTH'(4) : ACPRAM_ADDR_WIDTH'(1));
                rem_q         <= rem_q - LEN_WIDTH'(chunk_bytes);
            end
        end
    end

endmodule

// File: tb/tb_acp_xfer_splitter.sv
// Directed bench for acp_xfer_splitter: transfer-level command model, mover responder and
// a per-cycle compare process.
module tb_acp_xfer_splitter;

    typedef struct packed {
        logic             wr;
        logic [31:0]      axi;
        logic [9:0]       acp;
        logic             blen;
        logic [15:0]      ws0;
        logic [3:0]       ws0123;
        logic [3:0][15:0] loc;
    } cmd_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_axi_addr;
    logic [9:0]  req_acpram_addr;
    logic [15:0] req_len;
    logic        cmp_valid, cmp_error;
    logic        cmd_write, cmd_read;
    logic [31:0] cmd_axi_addr;
    logic [9:0]  cmd_acpram_addr;
    logic        cmd_len;
    logic        cmd_busy, cmd_done, cmd_error;
    logic [15:0] acp_remote_wstrb_0;
    logic [3:0]  acp_remote_wstrb_0123;
    logic [15:0] acp_local_wstrb [4];

    logic        mv_busy, hold_busy, mv_active;
    int          mv_lat, mv_err_idx, mv_chunk;
    assign cmd_busy = mv_busy | hold_busy;

    int   n_checks = 0, n_errors = 0;
    int   cyc = 0;
    int   accept_cyc, first_exp, last_done, exp_n, cmp_in_xfer;
    logic exp_err_v, xfer_active, in_cmd;
    cmd_t exp_q[$];
    cmd_t dut_log[$];
    cmd_t cur;

    acp_xfer_splitter #(
        .AXI_ADDR_WIDTH(32),
        .ACPRAM_ADDR_WIDTH(10),
        .LEN_WIDTH(16)
    ) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_axi_addr(req_axi_addr), .req_acpram_addr(req_acpram_addr), .req_len(req_len),
        .cmp_valid(cmp_valid), .cmp_error(cmp_error),
        .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_axi_addr(cmd_axi_addr), .cmd_acpram_addr(cmd_acpram_addr), .cmd_len(cmd_len),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_error(cmd_error),
        .acp_remote_wstrb_0(acp_remote_wstrb_0), .acp_remote_wstrb_0123(acp_remote_wstrb_0123),
        .acp_local_wstrb(acp_local_wstrb)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got an unexpected event, expected none (cycle %0d)", nm, cyc);
    endtask

    // Transfer-level model: walk the byte range and list the commands that must appear.
    function automatic int build(input logic wr, input logic [31:0] a, input logic [9:0] w, input int len);
        int rem = len;
        int n   = 0;
        while (rem > 0) begin
            cmd_t e;
            int   nb;
            e     = '0;
            e.wr  = wr;
            e.axi = a;
            e.acp = w;
            if ((a % 64) == 0 && rem >= 64) begin
                nb       = 64;
                e.blen   = 1'b1;
                e.ws0123 = 4'hF;
                for (int k = 0; k < 4; k++) e.loc[k] = 16'hFFFF;
                w = w + 10'd4;
            end else begin
                int off = int'(a % 16);
                nb = (16 - off < rem) ? 16 - off : rem;
                for (int b = off; b < off + nb; b++) e.ws0[b] = 1'b1;
                e.loc[0] = e.ws0;
                e.ws0123 = 4'b0001;
                w = w + 10'd1;
            end
            exp_q.push_back(e);
            a   = a + 32'(nb);
            rem = rem - nb;
            n++;
        end
        return n;
    endfunction

    // Mover responder: busy after the pulse, done (+ optional error) mv_lat cycles later.
    initial begin
        mv_busy = 0; cmd_done = 0; cmd_error = 0; mv_active = 0;
        forever begin
            @(negedge clock);
            if (resetn && (cmd_write || cmd_read)) begin
                mv_active = 1;
                @(posedge clock); #1 mv_busy = 1;
                repeat (mv_lat) @(posedge clock);
                #1 cmd_done = 1; cmd_error = (mv_chunk == mv_err_idx);
                mv_chunk++;
                @(posedge clock); #1 cmd_done = 0; cmd_error = 0; mv_busy = 0; mv_active = 0;
            end
        end
    end

    // Compare process.
    always @(negedge clock) begin
        if (resetn) begin
            if (cmd_write || cmd_read) begin
                chk("pulse_exclusive", 64'(cmd_write && cmd_read), 0);
                if (exp_q.size() == 0) begin
                    fail_event("unexpected_cmd");
                end else begin
                    cmd_t e, d;
                    e = exp_q.pop_front();
                    d = '0;
                    d.wr = cmd_write; d.axi = cmd_axi_addr; d.acp = cmd_acpram_addr; d.blen = cmd_len;
                    d.ws0 = acp_remote_wstrb_0; d.ws0123 = acp_remote_wstrb_0123;
                    for (int k = 0; k < 4; k++) d.loc[k] = acp_local_wstrb[k];
                    chk("cmd_dir", d.wr, e.wr);
                    chk("cmd_axi_addr", d.axi, e.axi);
                    chk("cmd_acpram_addr", d.acp, e.acp);
                    chk("cmd_len", d.blen, e.blen);
                    chk("wstrb_0123", d.ws0123, e.ws0123);
                    for (int k = 0; k < 4; k++) chk($sformatf("local_wstrb%0d", k), d.loc[k], e.loc[k]);
                    if (!e.blen) chk("wstrb_0", d.ws0, e.ws0);
                    if (first_exp >= 0) chk("first_cmd_latency", cyc, first_exp);
                    first_exp = -1;
                    cur    = e;
                    in_cmd = 1;
                    dut_log.push_back(d);
                end
            end
            if (cmd_done && in_cmd) begin
                chk("hold_axi_addr", cmd_axi_addr, cur.axi);
                chk("hold_acpram_addr", cmd_acpram_addr, cur.acp);
                chk("hold_len", cmd_len, cur.blen);
                chk("hold_local0", acp_local_wstrb[0], cur.loc[0]);
                in_cmd    = 0;
                last_done = cyc;
            end
            if (cmp_valid) begin
                cmp_in_xfer++;
                if (!xfer_active) begin
                    fail_event("unexpected_cmp");
                end else begin
                    chk("cmp_error", cmp_error, exp_err_v);
                    chk("cmds_outstanding", exp_q.size(), 0);
                    chk("cmp_latency", cyc, (exp_n == 0) ? accept_cyc + 1 : last_done + 1);
                    xfer_active = 0;
                end
            end
        end
    end

    task automatic start_req(input logic wr, input logic [31:0] a, input logic [9:0] w, input int len,
                             input int err_idx, input int pre_busy, input int lat);
        exp_q.delete();
        dut_log.delete();
        exp_n       = build(wr, a, w, len);
        exp_err_v   = (err_idx >= 0 && err_idx < exp_n);
        mv_err_idx  = err_idx;
        mv_chunk    = 0;
        mv_lat      = lat;
        cmp_in_xfer = 0;
        xfer_active = 1;
        first_exp   = -1;
        @(posedge clock); #1;
        if (pre_busy > 0) hold_busy = 1;
        req_write = wr; req_axi_addr = a; req_acpram_addr = w; req_len = 16'(len); req_valid = 1;
        @(posedge clock);
        accept_cyc = cyc;
        if (pre_busy == 0) first_exp = cyc + 1;
        #1 req_valid = 0;
        if (len == 0) begin
            chk("len0_ready_low", req_ready, 0);
            @(posedge clock); #1;
            chk("len0_ready_back", req_ready, 1);
        end
        if (pre_busy > 0) begin
            repeat (pre_busy) @(posedge clock);
            #1 hold_busy = 0;
            first_exp = cyc;
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [9:0] w, input int len,
                        input int err_idx, input int pre_busy, input int lat);
        start_req(wr, a, w, len, err_idx, pre_busy, lat);
        for (int i = 0; i < 2000 && cmp_in_xfer == 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        chk("cmp_once", cmp_in_xfer, 1);
        for (int i = 0; i < 100 && mv_active; i++) @(posedge clock);
    endtask

    initial begin
        resetn = 0; req_valid = 0; req_write = 0; req_axi_addr = '0; req_acpram_addr = '0; req_len = '0;
        hold_busy = 0; mv_lat = 1; mv_err_idx = -1; mv_chunk = 0;
        xfer_active = 0; in_cmd = 0; first_exp = -1; cmp_in_xfer = 0; exp_n = 0; last_done = 0; accept_cyc = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_cmp_valid", cmp_valid, 0);
        chk("rst_cmd_pulses", {cmd_write, cmd_read}, 0);
        chk("rst_cmd_axi_addr", cmd_axi_addr, 0);
        chk("rst_wstrb", {acp_remote_wstrb_0, acp_remote_wstrb_0123, acp_local_wstrb[0]}, 0);
        @(posedge clock); #1 resetn = 1;

        // Aligned 128 B write: two bursts.
        xfer(1, 32'h1000, 10'h000, 128, -1, 0, 1);
        chk("t1_ncmd", dut_log.size(), 2);
        if (dut_log.size() >= 2) begin
            chk("t1_axi0", dut_log[0].axi, 32'h1000);
            chk("t1_axi1", dut_log[1].axi, 32'h1040);
            chk("t1_acp1", dut_log[1].acp, 10'h004);
            chk("t1_len1", dut_log[1].blen, 1);
            chk("t1_wstrb0123", dut_log[0].ws0123, 4'hF);
        end

        // Unaligned 20 B write.
        xfer(1, 32'h1005, 10'h010, 20, -1, 0, 2);
        chk("t2_ncmd", dut_log.size(), 2);
        if (dut_log.size() >= 2) begin
            chk("t2_wstrb0_a", dut_log[0].ws0, 16'hFFE0);
            chk("t2_axi1", dut_log[1].axi, 32'h1010);
            chk("t2_acp1", dut_log[1].acp, 10'h011);
            chk("t2_wstrb0_b", dut_log[1].ws0, 16'h01FF);
        end

        // 64 B read not 64-aligned: four singles.
        xfer(0, 32'h1030, 10'h020, 64, -1, 0, 1);
        chk("t3_ncmd", dut_log.size(), 4);
        if (dut_log.size() >= 4) begin
            chk("t3_axi3", dut_log[3].axi, 32'h1060);
            chk("t3_local0", dut_log[2].loc[0], 16'hFFFF);
            chk("t3_len", dut_log[1].blen, 0);
            chk("t3_read", dut_log[0].wr, 0);
        end

        // Zero-length request.
        xfer(1, 32'h4000, 10'h000, 0, -1, 0, 1);
        chk("t4_ncmd", dut_log.size(), 0);

        // Error on chunk 2 of 3.
        xfer(1, 32'h1008, 10'h030, 40, 1, 0, 3);
        chk("t5_ncmd", dut_log.size(), 3);

        // Mixed read with the mover busy at accept time.
        xfer(0, 32'h0FF8, 10'h100, 100, -1, 3, 1);
        chk("t6_ncmd", dut_log.size(), 4);
        if (dut_log.size() >= 4) begin
            chk("t6_local0_first", dut_log[0].loc[0], 16'hFF00);
            chk("t6_burst", dut_log[1].blen, 1);
            chk("t6_acp2", dut_log[2].acp, 10'h105);
            chk("t6_local0_last", dut_log[3].loc[0], 16'h0FFF);
        end

        // Address wrap on both address spaces.
        xfer(1, 32'hFFFF_FFF0, 10'h3FF, 32, -1, 0, 1);
        if (dut_log.size() >= 2) begin
            chk("t7_axi_wrap", dut_log[1].axi, 32'h0000_0000);
            chk("t7_acp_wrap", dut_log[1].acp, 10'h000);
        end

        // Reset while waiting on the mover.
        start_req(1, 32'h3000, 10'h000, 128, -1, 0, 4);
        for (int i = 0; i < 50 && !mv_busy; i++) @(posedge clock);
        @(posedge clock); #1;
        xfer_active = 0; in_cmd = 0; exp_q.delete();
        resetn = 0;
        @(posedge clock); #1;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_cmd_pulses", {cmd_write, cmd_read}, 0);
        chk("abort_cmp_valid", cmp_valid, 0);
        resetn = 1;
        for (int i = 0; i < 100 && mv_active; i++) @(posedge clock);
        repeat (5) @(posedge clock);
        chk("abort_no_cmp", cmp_in_xfer, 0);

        // Recovery after abort: small write.
        xfer(1, 32'h2003, 10'h040, 3, -1, 0, 1);
        if (dut_log.size() >= 1) chk("t9_wstrb0", dut_log[0].ws0, 16'h0038);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
